// File: rtl/mux_pipe_nxw.sv
// N-input, W-bit channel selector with a STAGES-deep registered pipeline and
// valid/ready flow control. Out-of-range selects pass through as zero data with sel_err set.
module mux_pipe_nxw #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*WIDTH-1:0]   d,
  input  logic [SEL_W-1:0]          s,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  logic [WIDTH-1:0]  sel_data;
  logic              sel_bad;
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (s == SEL_W'(k)) begin
        sel_data = d[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  // Ready ripples back from the output; a local accumulator keeps rdy free of self-reads.
  always_comb begin
    logic r;
    r           = out_ready;
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r      = !v[i] || r;
      rdy[i] = r;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples
  // its upstream neighbour's pre-edge value; the data array is reset too, so Y reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      err_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= sel_data;
          err_q[0]  <= sel_bad;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            data_q[i] <= data_q[i-1];
            err_q[i]  <= err_q[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign y         = data_q[STAGES-1];
  assign out_valid = v[STAGES-1];
  // A stale err bit may linger in an emptied stage, so gate it with valid.
  assign sel_err   = err_q[STAGES-1] & v[STAGES-1];

endmodule

// File: tb/tb_mux_pipe_nxw.sv
// Scoreboard bench for mux_pipe_nxw: four parameter sets run side by side, each with
// its own driver pushing expected items and a negedge monitor popping and comparing.
module tb_mux_pipe_nxw;
  localparam int WIDTH = 32;
  localparam int NCFG  = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  function automatic int cfg_num_in(int c);
    case (c) 0: return 4; 1: return 3; 2: return 5; default: return 16; endcase
  endfunction
  function automatic int cfg_sel_w(int c);
    case (c) 0: return 2; 1: return 2; 2: return 3; default: return 4; endcase
  endfunction
  function automatic int cfg_stages(int c);
    case (c) 0: return 1; 1: return 3; 2: return 2; default: return 4; endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg_blk
    localparam int NUM_IN = cfg_num_in(g);
    localparam int SEL_W  = cfg_sel_w(g);
    localparam int STAGES = cfg_stages(g);

    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] d;
    logic [SEL_W-1:0]        s;
    logic                    in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [WIDTH-1:0]        y;
    bit                      done = 1'b0;

    exp_t             exp_q[$];
    bit               held = 1'b0;
    logic [WIDTH-1:0] held_y;
    logic             held_err;

    mux_pipe_nxw #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    function automatic string tag(input string n);
      return $sformatf("c%0d_%s", g, n);
    endfunction

    // Reference: pick channel s if it exists, otherwise zero data flagged as an error.
    function automatic exp_t model(input logic [NUM_IN*WIDTH-1:0] dv, input logic [SEL_W-1:0] sv);
      exp_t e;
      if (int'(sv) < NUM_IN) begin
        e.data = dv[int'(sv)*WIDTH +: WIDTH];
        e.err  = 1'b0;
      end else begin
        e.data = '0;
        e.err  = 1'b1;
      end
      return e;
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] rand_d();
      logic [NUM_IN*WIDTH-1:0] dv;
      for (int k = 0; k < NUM_IN; k++) dv[k*WIDTH +: WIDTH] = $urandom();
      return dv;
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] dir_d();
      logic [NUM_IN*WIDTH-1:0] dv;
      logic [31:0] vals [4];
      dv = rand_d();
      if (NUM_IN == 3) vals = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h5555_5555, 32'h0};
      else             vals = '{32'h1234_5678, 32'h8765_4321, 32'hABCD_EF01, 32'h1010_1010};
      for (int k = 0; k < 4 && k < NUM_IN; k++) dv[k*WIDTH +: WIDTH] = vals[k];
      return dv;
    endfunction

    // One clock cycle: drive at posedge+1, observe handshake at negedge, return at posedge+1.
    task automatic step(input bit iv, input logic [NUM_IN*WIDTH-1:0] dv, input logic [SEL_W-1:0] sv,
                        input bit ordy, output bit acc, output bit ir, output bit ov);
      in_valid  = iv;
      d         = dv;
      s         = sv;
      out_ready = ordy;
      @(negedge clk);
      ir  = in_ready;
      ov  = out_valid;
      acc = iv && in_ready;
      if (acc) exp_q.push_back(model(dv, sv));
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      bit a, r, o;
      for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b1, a, r, o);
    endtask

    always @(negedge clk) begin
      if (rst) begin
        held = 1'b0;
      end else begin
        if (!out_valid) check(tag("idle_err"), 32'(sel_err), 32'(0));
        if (held && out_valid) begin
          check(tag("stall_y"), 32'(y), 32'(held_y));
          check(tag("stall_err"), 32'(sel_err), 32'(held_err));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check(tag("spurious_out"), 32'(exp_q.size()), 32'(1));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(tag("y"), 32'(y), 32'(e.data));
            check(tag("sel_err"), 32'(sel_err), 32'(e.err));
          end
        end
        held     = out_valid && !out_ready;
        held_y   = y;
        held_err = sel_err;
      end
    end

    initial begin
      bit acc, ir, ov;
      int stored, first_k;
      logic [NUM_IN*WIDTH-1:0] dv;
      logic [SEL_W-1:0] sv;
      int n_dir;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = '0; s = '0;
      #1;
      check(tag("rst_out_valid"), 32'(out_valid), 32'(0));
      check(tag("rst_y"), 32'(y), 32'(0));
      check(tag("rst_sel_err"), 32'(sel_err), 32'(0));
      check(tag("rst_in_ready"), 32'(in_ready), 32'(1));
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Directed select sweep with the fixed channel pattern, including out-of-range codes.
      n_dir = (2**SEL_W < 8) ? 2**SEL_W : 8;
      for (int k = 0; k < n_dir; k++) begin
        step(1'b1, dir_d(), SEL_W'(k), 1'b1, acc, ir, ov);
        check(tag("dir_accept"), 32'(acc), 32'(1));
      end
      if (NUM_IN == 3) step(1'b1, dir_d(), SEL_W'(2), 1'b1, acc, ir, ov);
      idle(STAGES + 1);
      check(tag("dir_drained"), 32'(exp_q.size()), 32'(0));

      // Back-to-back fill with the output blocked, then release on a pending item.
      stored = 0;
      for (int k = 0; k <= STAGES; k++) begin
        dv = rand_d(); sv = SEL_W'($urandom());
        step(1'b1, dv, sv, 1'b0, acc, ir, ov);
        check(tag("fill_ready"), 32'(ir), 32'(stored < STAGES));
        if (acc) stored++;
      end
      step(1'b1, dv, sv, 1'b1, acc, ir, ov);
      check(tag("accept_on_ready"), 32'(acc), 32'(1));
      idle(STAGES + 2);
      check(tag("fill_drained"), 32'(exp_q.size()), 32'(0));

      // Alternating valid with the output blocked: items pack with no gaps.
      stored = 0;
      for (int k = 0; k < 2*STAGES + 2; k++) begin
        step((k % 2) == 0, rand_d(), SEL_W'($urandom()), 1'b0, acc, ir, ov);
        check(tag("bubble_ready"), 32'(ir), 32'(stored < STAGES));
        if (acc) stored++;
      end
      check(tag("bubble_count"), 32'(stored), 32'(STAGES));
      for (int k = 0; k <= STAGES; k++) begin
        step(1'b0, '0, '0, 1'b1, acc, ir, ov);
        check(tag("bubble_drain"), 32'(ov), 32'(k < STAGES));
      end

      // Random traffic with random backpressure.
      for (int k = 0; k < 300; k++)
        step($urandom_range(0, 3) != 0, rand_d(), SEL_W'($urandom()),
             $urandom_range(0, 3) != 0, acc, ir, ov);
      idle(STAGES + 2);
      check(tag("rand_drained"), 32'(exp_q.size()), 32'(0));

      // Asynchronous reset with items in flight.
      step(1'b1, rand_d(), SEL_W'($urandom()), 1'b0, acc, ir, ov);
      step(1'b1, rand_d(), SEL_W'($urandom()), 1'b0, acc, ir, ov);
      #2 rst = 1'b1;
      #1;
      check(tag("midrst_out_valid"), 32'(out_valid), 32'(0));
      check(tag("midrst_y"), 32'(y), 32'(0));
      check(tag("midrst_sel_err"), 32'(sel_err), 32'(0));
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      dv = rand_d();
      dv[WIDTH +: WIDTH] = 32'h8765_4321;
      step(1'b1, dv, SEL_W'(1), 1'b1, acc, ir, ov);
      check(tag("postrst_accept"), 32'(acc), 32'(1));
      first_k = -1;
      for (int k = 1; k <= STAGES + 1; k++) begin
        step(1'b0, '0, '0, 1'b1, acc, ir, ov);
        if (ov && first_k < 0) first_k = k;
      end
      check(tag("postrst_latency"), 32'(first_k), 32'(STAGES));
      check(tag("postrst_drained"), 32'(exp_q.size()), 32'(0));

      // Sustained stream: one accept per cycle and gap-free output after STAGES cycles.
      for (int k = 0; k < 100 + STAGES; k++) begin
        step(k < 100, rand_d(), SEL_W'($urandom()), 1'b1, acc, ir, ov);
        if (k < 100) check(tag("sus_accept"), 32'(acc), 32'(1));
        check(tag("sus_out_valid"), 32'(ov), 32'(k >= STAGES));
      end
      idle(2);
      check(tag("sus_drained"), 32'(exp_q.size()), 32'(0));
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (cfg_blk[0].done && cfg_blk[1].done && cfg_blk[2].done && cfg_blk[3].done);
      begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected all configurations done");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_pipe_nxw.md
Name: mux_pipe_nxw

Overview:
- Parametrised N-input, W-bit selector with a registered pipeline and valid/ready flow control.
- Successor to the fixed 4x32 combinational mux in the datapath. Used wherever operand/result selection must be retimed or can stall, such as the writeback select and the forwarding select into the ALU.
- Adds out-of-range select detection, backpressure and configurable latency.

Parameters:
- WIDTH, 32, data width of each input channel and of Y.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, 2, width of S; must satisfy 2**SEL_W >= NUM_IN.
- STAGES, 1, number of pipeline register stages; legal range 1..4.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- D  in  NUM_IN*WIDTH  flattened inputs; channel k occupies D[k*WIDTH +: WIDTH].
- S  in  SEL_W  channel select, sampled with D.
- In_Valid  in  1  D and S are valid this cycle.
- In_Ready  out  1  block accepts D/S this cycle.
- Y  out  WIDTH  selected data from the last stage.
- Out_Valid  out  1  Y and Sel_Err are valid.
- Out_Ready  in  1  downstream accepts Y this cycle.
- Sel_Err  out  1  the item on Y had S >= NUM_IN.

Behaviour:
- Reset (async, Rst=1): all stage valid bits 0, all stage data 0, all stage err bits 0. This gives Y=0, Out_Valid=0, Sel_Err=0.
- Release of Rst takes effect on the next rising Clk edge.
- Select: sel = D channel S when S < NUM_IN. When S >= NUM_IN, sel = 0 and err = 1; the item is still transferred, not dropped.
- Pipeline: stages 0..STAGES-1, each holding {valid, data, err}.
- rdy[STAGES] = Out_Ready.
- rdy[i] = !v[i] | rdy[i+1], combinational. Empty stages accept, so bubbles collapse.
- In_Ready = rdy[0]. It is combinational from Out_Ready and the valid bits, and does not depend on In_Valid.
- Stage 0 update when rdy[0]: v0 <= In_Valid, with data/err loaded only if In_Valid.
- Stage i>0 update when rdy[i]: v[i] <= v[i-1], with data/err loaded from stage i-1 only if v[i-1].
- When rdy[i]=0, stage i holds all of its contents.
- Y, Out_Valid and Sel_Err come directly from the last stage registers. No combinational path from D or S to Y.
- Latency: an item accepted at edge n appears on Y after edge n+STAGES-1, i.e. on Out_Valid that cycle, given no stall. Throughput is 1 item/cycle sustained with Out_Ready=1.
- Stall: while Out_Valid=1 and Out_Ready=0, Y and Sel_Err must stay stable. Once all stages are valid, In_Ready=0.
- Full pipe with Out_Ready=1 and In_Valid=1: simultaneous accept and emit, with no bubble inserted.
- Empty pipe with Out_Ready=0: In_Ready=1, and STAGES items are accepted before In_Ready drops.
- No item is lost or duplicated. Output order equals input order.
- Reset mid-operation: all in-flight items are discarded immediately (async). Out_Valid drops in the same cycle Rst asserts.
- Data bits of non-valid stages are don't-care beyond reset, but must not toggle Sel_Err while Out_Valid=0. Sel_Err is gated to 0 when v=0.

Test Plan:
- Basic select, STAGES=1:
  - Stimulus: D = {10101010, ABCDEF01, 87654321, 12345678} (ch3..ch0), In_Valid=1, Out_Ready=1, S stepping 0,1,2,3 on consecutive cycles.
  - Required: Y = 12345678, 87654321, ABCDEF01, 10101010, each one cycle after acceptance, with Out_Valid=1 throughout and Sel_Err=0.
- Out-of-range select:
  - Stimulus: NUM_IN=3, SEL_W=2, S=3, D ch0..2 = FFFFFFFF, 00000000, 55555555.
  - Required: Y=00000000, Sel_Err=1, Out_Valid=1. The next item with S=2 gives Y=55555555, Sel_Err=0.
- Backpressure, STAGES=3:
  - Stimulus: Out_Ready=0, 4 consecutive valid items.
  - Required: In_Ready=1 for the first 3 items, then In_Ready=0. Y holds item 0 stable.
  - Then Out_Ready=1 for 4 cycles: items 0..3 emerge in order, and item 3 is accepted the cycle Out_Ready rises.
- Bubble collapse, STAGES=3:
  - Stimulus: alternate In_Valid 1/0 with Out_Ready=0 for 6 cycles.
  - Required: 3 items stored with no gaps, then In_Ready=0. Draining yields 3 back-to-back Out_Valid cycles.
- Reset mid-flight, STAGES=2:
  - Stimulus: 2 items in flight, assert Rst between clock edges.
  - Required: Out_Valid=0, Y=0 and Sel_Err=0 immediately. After release, the first new item (S=1, ch1=87654321) appears 2 cycles after acceptance.
- Sustained throughput, STAGES=4:
  - Stimulus: 100 random items with Out_Ready=1.
  - Required: output sequence matches the scoreboard exactly, with first Out_Valid 4 cycles after first acceptance and no bubbles after that.
